// File: rtl/mul_pkg.sv
// Shared widths and the partial-product bundle for the two-stage 32x32 multiplier.
package mul_pkg;

   localparam int OP_W   = 32;
   localparam int HALF_W = 16;
   localparam int PROD_W = 64;
   localparam int RES_W  = 65;

   typedef struct packed {
      logic [2*HALF_W-1:0] ll;
      logic [2*HALF_W-1:0] lh;
      logic [2*HALF_W-1:0] hl;
      logic [2*HALF_W-1:0] hh;
   } pp_t;

endpackage

// File: rtl/mul16x16.sv
// Combinational unsigned 16x16 -> 32 multiplier used for one partial product.
module mul16x16
   import mul_pkg::*;
(
   input  logic [HALF_W-1:0]   a,
   input  logic [HALF_W-1:0]   b,
   output logic [2*HALF_W-1:0] p
);

   assign p = a * b;

endmodule

// File: rtl/multiplier.sv
// Two-stage pipelined unsigned 32x32 multiplier with a zero-extended 65-bit result,
// a one-cycle valid pulse per accepted operation and an upper-half overflow flag.
module multiplier
   import mul_pkg::*;
#(
   parameter int WIDTH = OP_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [WIDTH-1:0]   op1,
   input  logic [WIDTH-1:0]   op2,
   output logic [2*WIDTH:0]   res,
   output logic               val,
   output logic               overflow
);

   pp_t               pp_c;
   pp_t               pp_p1;
   logic              vld_p1;
   logic [PROD_W-1:0] prod_c;

   function automatic logic upper_nonzero(input logic [PROD_W-1:0] p);
      return |p[PROD_W-1:OP_W];
   endfunction

   function automatic logic [RES_W-1:0] zero_extend(input logic [PROD_W-1:0] p);
      return {1'b0, p};
   endfunction

   mul16x16 u_ll (.a(op1[HALF_W-1:0]),    .b(op2[HALF_W-1:0]),    .p(pp_c.ll));
   mul16x16 u_lh (.a(op1[HALF_W-1:0]),    .b(op2[OP_W-1:HALF_W]), .p(pp_c.lh));
   mul16x16 u_hl (.a(op1[OP_W-1:HALF_W]), .b(op2[HALF_W-1:0]),    .p(pp_c.hl));
   mul16x16 u_hh (.a(op1[OP_W-1:HALF_W]), .b(op2[OP_W-1:HALF_W]), .p(pp_c.hh));

   // ---- stage 1: register partial products ----
   always_ff @(posedge clk) begin
      if (reset) begin
         pp_p1  <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= en;
         if (en) pp_p1 <= pp_c;
      end
   end

   // The 64-bit sum is exact: the true product never exceeds 2^64 - 1.
   always_comb begin
      prod_c = PROD_W'(pp_p1.ll)
             + (PROD_W'(pp_p1.lh) << HALF_W)
             + (PROD_W'(pp_p1.hl) << HALF_W)
             + (PROD_W'(pp_p1.hh) << OP_W);
   end

   // ---- stage 2: reduce, flag overflow, register outputs ----
   always_ff @(posedge clk) begin
      if (reset) begin
         res      <= '0;
         overflow <= 1'b0;
         val      <= 1'b0;
      end else begin
         val <= vld_p1;
         if (vld_p1) begin
            res      <= zero_extend(prod_c);
            overflow <= upper_nonzero(prod_c);
         end
      end
   end

endmodule

// File: tb/tb_multiplier.sv
// Directed-vector bench for the two-stage multiplier: reset, single ops, corners,
// back-to-back issue, idle operand toggling and reset during an in-flight op.
module tb_multiplier;

   logic        clk;
   logic        reset;
   logic        en;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [64:0] res;
   logic        val;
   logic        overflow;

   int checks;
   int errors;

   multiplier #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .en(en), .op1(op1), .op2(op2),
      .res(res), .val(val), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; en = 1'b0; op1 = '0; op2 = '0;
      repeat (3) tick();
      checks++;
      if (val !== 1'b0) begin errors++; $display("FAIL reset_val got %b want 0", val); end
      checks++;
      if (res !== 65'h0) begin errors++; $display("FAIL reset_res got %h want 0", res); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
      reset = 1'b0;
      tick();
      checks++;
      if (val !== 1'b0) begin errors++; $display("FAIL idle_after_reset_val got %b want 0", val); end
   endtask

   task automatic test_basic();
      op1 = 32'd48; op2 = 32'd56; en = 1'b1;
      tick();
      en = 1'b0;
      checks++;
      if (val !== 1'b0) begin errors++; $display("FAIL basic_early_val got %b want 0", val); end
      tick();
      checks++;
      if (val !== 1'b1) begin errors++; $display("FAIL basic_val got %b want 1", val); end
      checks++;
      if (res !== 65'd2688) begin errors++; $display("FAIL basic_res got %h want %h", res, 65'd2688); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", overflow); end
      tick();
      checks++;
      if (val !== 1'b0) begin errors++; $display("FAIL basic_val_drop got %b want 0", val); end
      checks++;
      if (res !== 65'd2688) begin errors++; $display("FAIL basic_hold got %h want %h", res, 65'd2688); end
   endtask

   task automatic test_max();
      op1 = 32'hFFFF_FFFF; op2 = 32'hFFFF_FFFF; en = 1'b1;
      tick();
      en = 1'b0;
      tick();
      checks++;
      if (val !== 1'b1) begin errors++; $display("FAIL max_val got %b want 1", val); end
      checks++;
      if (res !== 65'h0_FFFF_FFFE_0000_0001) begin
         errors++; $display("FAIL max_res got %h want %h", res, 65'h0_FFFF_FFFE_0000_0001);
      end
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL max_ovf got %b want 1", overflow); end
      checks++;
      if (res[64] !== 1'b0) begin errors++; $display("FAIL max_bit64 got %b want 0", res[64]); end
   endtask

   task automatic test_boundary();
      op1 = 32'h0001_0000; op2 = 32'h0001_0000; en = 1'b1;
      tick();
      en = 1'b0;
      tick();
      checks++;
      if (res !== 65'h1_0000_0000) begin errors++; $display("FAIL bit32_res got %h want %h", res, 65'h1_0000_0000); end
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL bit32_ovf got %b want 1", overflow); end
      op1 = 32'h0000_FFFF; op2 = 32'h0001_0001; en = 1'b1;
      tick();
      en = 1'b0;
      tick();
      checks++;
      if (val !== 1'b1) begin errors++; $display("FAIL fit_val got %b want 1", val); end
      checks++;
      if (res !== 65'h0_FFFF_FFFF) begin errors++; $display("FAIL fit_res got %h want %h", res, 65'h0_FFFF_FFFF); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL fit_ovf got %b want 0", overflow); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a [3];
      logic [31:0] b [3];
      logic [64:0] exp_res [3];
      logic        exp_ovf [3];
      a[0] = 32'd3;          b[0] = 32'd4;   exp_res[0] = 65'd12;          exp_ovf[0] = 1'b0;
      a[1] = 32'd0;          b[1] = 32'd123; exp_res[1] = 65'd0;           exp_ovf[1] = 1'b0;
      a[2] = 32'h8000_0000;  b[2] = 32'd2;   exp_res[2] = 65'h1_0000_0000; exp_ovf[2] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) begin
            op1 = a[i]; op2 = b[i]; en = 1'b1;
         end else begin
            en = 1'b0;
         end
         tick();
         if (i > 0) begin
            checks++;
            if (val !== 1'b1) begin errors++; $display("FAIL b2b_val[%0d] got %b want 1", i-1, val); end
            checks++;
            if (res !== exp_res[i-1]) begin
               errors++; $display("FAIL b2b_res[%0d] got %h want %h", i-1, res, exp_res[i-1]);
            end
            checks++;
            if (overflow !== exp_ovf[i-1]) begin
               errors++; $display("FAIL b2b_ovf[%0d] got %b want %b", i-1, overflow, exp_ovf[i-1]);
            end
         end
      end
      tick();
      checks++;
      if (val !== 1'b0) begin errors++; $display("FAIL b2b_tail_val got %b want 0", val); end
   endtask

   task automatic test_idle_toggle();
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         op1 = $urandom; op2 = $urandom;
         tick();
         checks++;
         if (val !== 1'b0) begin errors++; $display("FAIL idle_val[%0d] got %b want 0", i, val); end
         checks++;
         if (res !== 65'h1_0000_0000) begin
            errors++; $display("FAIL idle_res[%0d] got %h want %h", i, res, 65'h1_0000_0000);
         end
      end
   endtask

   task automatic test_reset_mid();
      op1 = 32'd7; op2 = 32'd9; en = 1'b1;
      tick();
      en = 1'b0; reset = 1'b1;
      tick();
      checks++;
      if (val !== 1'b0) begin errors++; $display("FAIL midrst_val got %b want 0", val); end
      checks++;
      if (res !== 65'h0) begin errors++; $display("FAIL midrst_res got %h want 0", res); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b want 0", overflow); end
      reset = 1'b0;
      tick();
      checks++;
      if (val !== 1'b0) begin errors++; $display("FAIL midrst_no_pulse got %b want 0", val); end
      // reset priority over en, then acceptance on the first edge after release
      reset = 1'b1; op1 = 32'd11; op2 = 32'd13; en = 1'b1;
      tick();
      reset = 1'b0; op1 = 32'd5; op2 = 32'd6;
      tick();
      en = 1'b0;
      checks++;
      if (val !== 1'b0) begin errors++; $display("FAIL rst_prio_val got %b want 0", val); end
      tick();
      checks++;
      if (val !== 1'b1) begin errors++; $display("FAIL post_rst_val got %b want 1", val); end
      checks++;
      if (res !== 65'd30) begin errors++; $display("FAIL post_rst_res got %h want %h", res, 65'd30); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1; en = 1'b0; op1 = '0; op2 = '0;
      test_reset();
      test_basic();
      test_max();
      test_boundary();
      test_back_to_back();
      test_idle_toggle();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
